// File: rtl/safecrack_autodialer.sv
// safecrack_autodialer: brute-force keypad initiator for the safecrack lock.
// Sends a wake press followed by CODE_LEN digit presses per attempt, then
// classifies the lock's response (unlock / error / lockout) and steps the code.
// Optional build macro: SAFECRACK_AUTODIALER_STATS_EN builds the attempt and
// lockout counters; without it both ports read constant zero.
module safecrack_autodialer #(
  parameter int CLOCK_HZ     = 50_000_000,
  parameter int CODE_LEN     = 4,
  parameter int PRESS_CYC    = 4,
  parameter int GAP_CYC      = 4,
  parameter int SETTLE_CYC   = 8,
  parameter int ERR_WAIT_CYC = CLOCK_HZ / 5 + 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [2*CODE_LEN-1:0] start_code,
  input  logic [8:0]            lock_ledg,
  input  logic [17:0]           lock_ledr,
  output logic [3:0]            KEY_n,
  output logic                  busy,
  output logic                  found,
  output logic                  exhausted,
  output logic [2*CODE_LEN-1:0] found_code,
  output logic [2*CODE_LEN-1:0] cur_code,
  output logic [15:0]           attempts,
  output logic [7:0]            lockouts
);

  localparam int CW    = 2 * CODE_LEN;
  localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  typedef enum logic [3:0] {
    IDLE, WAKE_P, WAKE_G, DIG_P, DIG_G, SETTLE, EVAL,
    ERR_WAIT, LOCK_WAIT, FOUND, EXHAUSTED
  } state_t;

  state_t           state;
  logic [31:0]      cnt;
  logic [IDX_W-1:0] idx;
  logic [CW-1:0]    digits_sh;
  logic [CW-1:0]    start_lat;
  logic [CW-1:0]    next_code;
  logic             do_adv;

  // Only the status bits the dialer reacts to are consumed.
  logic unused_led_bits;
  assign unused_led_bits = ^{lock_ledg[6:0], lock_ledr[17:9], lock_ledr[7:0]};

  // Active-low one-hot key drive for a 2-bit digit.
  function automatic logic [3:0] key_drive(input logic [1:0] d);
    return ~(4'b0001 << d);
  endfunction

`ifdef SAFECRACK_AUTODIALER_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`else
  assign attempts = 16'd0;
  assign lockouts = 8'd0;
`endif

  assign next_code = cur_code + {{(CW-1){1'b0}}, 1'b1};

  // Attempt finished and the post-result wait has elapsed: step to the next code.
  always_comb begin
    do_adv = 1'b0;
    if (state == ERR_WAIT && cnt == 32'(ERR_WAIT_CYC - 1))
      do_adv = 1'b1;
    else if (state == LOCK_WAIT && !lock_ledr[8] && cnt == 32'(GAP_CYC - 1))
      do_adv = 1'b1;
  end

  // Main sequencer: key timing, result classification and code enumeration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 32'd0;
      idx        <= '0;
      digits_sh  <= '0;
      start_lat  <= '0;
      KEY_n      <= 4'hF;
      busy       <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      found_code <= '0;
      cur_code   <= '0;
`ifdef SAFECRACK_AUTODIALER_STATS_EN
      attempts   <= 16'd0;
      lockouts   <= 8'd0;
`endif
    end else if (abort) begin
      state <= IDLE;
      cnt   <= 32'd0;
      KEY_n <= 4'hF;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE, FOUND, EXHAUSTED: begin
          if (start && !lock_ledg[7]) begin
            state     <= WAKE_P;
            cnt       <= 32'd0;
            KEY_n     <= 4'hE;
            busy      <= 1'b1;
            found     <= 1'b0;
            exhausted <= 1'b0;
            cur_code  <= start_code;
            start_lat <= start_code;
`ifdef SAFECRACK_AUTODIALER_STATS_EN
            attempts  <= 16'd0;
            lockouts  <= 8'd0;
`endif
          end
        end

        WAKE_P: begin
          if (cnt == 32'(PRESS_CYC - 1)) begin
            state <= WAKE_G;
            cnt   <= 32'd0;
            KEY_n <= 4'hF;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        WAKE_G: begin
          if (cnt == 32'(GAP_CYC - 1)) begin
            state     <= DIG_P;
            cnt       <= 32'd0;
            idx       <= '0;
            KEY_n     <= key_drive(cur_code[CW-1 -: 2]);
            digits_sh <= cur_code << 2;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        DIG_P: begin
          if (cnt == 32'(PRESS_CYC - 1)) begin
            cnt   <= 32'd0;
            KEY_n <= 4'hF;
            // The final gap is absorbed into the settle window.
            if (idx == IDX_W'(CODE_LEN - 1))
              state <= SETTLE;
            else
              state <= DIG_G;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        DIG_G: begin
          if (cnt == 32'(GAP_CYC - 1)) begin
            state     <= DIG_P;
            cnt       <= 32'd0;
            idx       <= idx + 1'b1;
            KEY_n     <= key_drive(digits_sh[CW-1 -: 2]);
            digits_sh <= digits_sh << 2;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        SETTLE: begin
          if (cnt == 32'(SETTLE_CYC - 1)) begin
            state <= EVAL;
            cnt   <= 32'd0;
`ifdef SAFECRACK_AUTODIALER_STATS_EN
            attempts <= sat_inc16(attempts);
`endif
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        EVAL: begin
          cnt <= 32'd0;
          if (lock_ledg[7]) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (lock_ledg[8]) begin
            state      <= FOUND;
            busy       <= 1'b0;
            found      <= 1'b1;
            found_code <= cur_code;
          end else if (lock_ledr[8]) begin
            state <= LOCK_WAIT;
`ifdef SAFECRACK_AUTODIALER_STATS_EN
            lockouts <= sat_inc8(lockouts);
`endif
          end else begin
            state <= ERR_WAIT;
          end
        end

        ERR_WAIT, LOCK_WAIT: begin
          if (do_adv) begin
            cnt      <= 32'd0;
            cur_code <= next_code;
            if (next_code == start_lat) begin
              state     <= EXHAUSTED;
              busy      <= 1'b0;
              exhausted <= 1'b1;
            end else begin
              state <= WAKE_P;
              KEY_n <= 4'hE;
            end
          end else if (state == LOCK_WAIT && lock_ledr[8]) begin
            // Gap timing restarts once the lockout indicator drops.
            cnt <= 32'd0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= 32'd0;
          KEY_n <= 4'hF;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_safecrack_autodialer.sv
// Scoreboard bench for safecrack_autodialer with a behavioural lock model.
module tb_safecrack_autodialer;

  localparam int LOCK_CYC = 100;
  localparam int ERR_CYC  = 20;
  localparam int RUN_BUDGET = 40000;

`ifdef SAFECRACK_AUTODIALER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  start_code = 8'h00;
  logic [8:0]  lock_ledg;
  logic [17:0] lock_ledr;
  logic [3:0]  KEY_n;
  logic        busy, found, exhausted;
  logic [7:0]  found_code, cur_code;
  logic [15:0] attempts;
  logic [7:0]  lockouts;

  always #5 clk = ~clk;

  safecrack_autodialer #(.CLOCK_HZ(100), .CODE_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .start_code(start_code), .lock_ledg(lock_ledg), .lock_ledr(lock_ledr),
    .KEY_n(KEY_n), .busy(busy), .found(found), .exhausted(exhausted),
    .found_code(found_code), .cur_code(cur_code),
    .attempts(attempts), .lockouts(lockouts)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural lock ----------------
  // 0 READY, 1 ENTRY, 2 OPEN, 3 ERROR blink, 4 LOCKOUT
  int         lk_state = 0;
  int         lk_idx = 0, lk_errs = 0, lk_tmr = 0;
  logic [7:0] lk_code = 8'h00;
  logic [7:0] lk_entered = 8'h00;
  logic [7:0] lk_e;
  logic       lk_never = 1'b0, lk_clear = 1'b0, prog = 1'b0;
  logic [3:0] lk_kprev = 4'hF;
  logic       lk_press;

  function automatic logic [1:0] key_digit(input logic [3:0] k);
    case (k)
      4'hD:    return 2'd1;
      4'hB:    return 2'd2;
      4'h7:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign lk_press  = (lk_kprev == 4'hF) && (KEY_n != 4'hF);
  assign lk_e      = {lk_entered[5:0], key_digit(KEY_n)};
  assign lock_ledg = {(lk_state == 2), prog, 7'd0};
  assign lock_ledr = {9'd0, (lk_state == 4), 7'd0, (lk_state == 3)};

  always @(posedge clk) begin
    lk_kprev <= KEY_n;
    if (lk_clear) begin
      lk_state <= 0;
      lk_idx   <= 0;
      lk_errs  <= 0;
    end else begin
      case (lk_state)
        0: if (lk_press) begin
          lk_state   <= 1;
          lk_idx     <= 0;
          lk_entered <= 8'h00;
        end
        1: if (lk_press) begin
          if (lk_idx == 3) begin
            if (lk_e == lk_code && !lk_never) begin
              lk_state <= 2;
            end else if (lk_errs == 2) begin
              lk_state <= 4;
              lk_tmr   <= LOCK_CYC;
              lk_errs  <= 0;
            end else begin
              lk_state <= 3;
              lk_tmr   <= ERR_CYC;
              lk_errs  <= lk_errs + 1;
            end
          end else begin
            lk_idx     <= lk_idx + 1;
            lk_entered <= lk_e;
          end
        end
        3, 4: begin
          if (lk_tmr <= 1) lk_state <= 0;
          lk_tmr <= lk_tmr - 1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        f;
    logic        e;
    logic [7:0]  fc;
    logic [15:0] att;
    logic [7:0]  lo;
    int          nk;
    logic [19:0] keys;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] klog[$];
  logic       busy_q = 1'b0;
  logic [3:0] kmprev = 4'hF;
  int         viol = 0;

  task automatic expect_run(input logic f, input logic e, input logic [7:0] fc,
                            input int att, input int lo, input int nk, input logic [19:0] keys);
    exp_t x;
    x.f = f; x.e = e; x.fc = fc;
    x.att = STATS ? 16'(att) : 16'd0;
    x.lo  = STATS ? 8'(lo) : 8'd0;
    x.nk = nk; x.keys = keys;
    sb.push_back(x);
  endtask

  // Monitor: log presses, check key exclusivity, compare at end of each run.
  always @(negedge clk) begin
    exp_t       x;
    logic [19:0] kk;
    logic [3:0]  got;
    int          zeros;
    zeros = 0;
    for (int i = 0; i < 4; i++) if (!KEY_n[i]) zeros++;
    if (zeros > 1) viol++;
    if (busy && !busy_q) klog.delete();
    if (KEY_n != 4'hF && kmprev == 4'hF) klog.push_back(KEY_n);
    if (busy_q && !busy) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_run_end actual=busy_fell required=no_run");
      end else begin
        x = sb.pop_front();
        chk("found", 32'(found), 32'(x.f));
        chk("exhausted", 32'(exhausted), 32'(x.e));
        chk("found_code", 32'(found_code), 32'(x.fc));
        chk("attempts", 32'(attempts), 32'(x.att));
        chk("lockouts", 32'(lockouts), 32'(x.lo));
        kk = x.keys;
        for (int i = 0; i < x.nk; i++) begin
          got = (i < klog.size()) ? klog[i] : 4'h0;
          chk($sformatf("key_seq[%0d]", i), 32'(got), 32'(kk[19-4*i -: 4]));
        end
      end
    end
    busy_q <= busy;
    kmprev <= KEY_n;
  end

  // ---------------- stimulus ----------------
  task automatic lock_setup(input logic [7:0] code, input logic never);
    @(negedge clk);
    lk_code  = code;
    lk_never = never;
    lk_clear = 1'b1;
    @(negedge clk);
    lk_clear = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] c);
    @(negedge clk);
    start_code = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < RUN_BUDGET) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL run_timeout actual=busy required=idle");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_presses(input int n);
    logic [3:0] p = 4'hF;
    int c = 0;
    int t = 0;
    while (t < 1000) begin
      if (p == 4'hF && KEY_n != 4'hF) c++;
      p = KEY_n;
      if (c >= n) break;
      @(negedge clk);
      t++;
    end
    total++;
    if (c < n) begin
      bad++;
      $display("FAIL press_timeout actual=%0d required=%0d", c, n);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_KEY_n", 32'(KEY_n), 32'hF);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_found", 32'(found), 32'h0);
    chk("rst_exhausted", 32'(exhausted), 32'h0);
    chk("rst_found_code", 32'(found_code), 32'h0);
    chk("rst_cur_code", 32'(cur_code), 32'h0);
    chk("rst_attempts", 32'(attempts), 32'h0);
    chk("rst_lockouts", 32'(lockouts), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Right code first try: presses wake, 2, 1, 3, 0
    lock_setup(8'h9C, 1'b0);
    expect_run(1'b1, 1'b0, 8'h9C, 1, 0, 5, {4'hE, 4'hB, 4'hD, 4'h7, 4'hE});
    do_start(8'h9C);
    chk("busy_after_start", 32'(busy), 32'h1);
    wait_idle();

    // Two errors, lockout on 02, then 03 opens
    lock_setup(8'h03, 1'b0);
    expect_run(1'b1, 1'b0, 8'h03, 4, 1, 0, 20'h0);
    do_start(8'h00);
    wait_idle();

    // Abort during the second digit press; found_code kept, found cleared
    lock_setup(8'h9C, 1'b0);
    expect_run(1'b0, 1'b0, 8'h03, 0, 0, 0, 20'h0);
    do_start(8'h9C);
    wait_presses(3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_KEY_n", 32'(KEY_n), 32'hF);
    chk("abort_busy", 32'(busy), 32'h0);
    repeat (5) @(negedge clk);

    // Restart after abort completes normally
    lock_setup(8'h9C, 1'b0);
    expect_run(1'b1, 1'b0, 8'h9C, 1, 0, 5, {4'hE, 4'hB, 4'hD, 4'h7, 4'hE});
    do_start(8'h9C);
    wait_idle();

    // Wrap FF -> 00, found on attempt 256
    lock_setup(8'h00, 1'b0);
    expect_run(1'b1, 1'b0, 8'h00, 256, 85, 0, 20'h0);
    do_start(8'h01);
    wait_idle();

    // Lock never opens: full enumeration then exhausted
    lock_setup(8'h00, 1'b1);
    expect_run(1'b0, 1'b1, 8'h00, 256, 85, 0, 20'h0);
    do_start(8'h01);
    wait_idle();
    chk("exhausted_cur_code", 32'(cur_code), 32'h01);

    // Async reset mid-press
    lock_setup(8'h9C, 1'b0);
    expect_run(1'b0, 1'b0, 8'h00, 0, 0, 0, 20'h0);
    do_start(8'h9C);
    wait_presses(2);
    chk("midpress_key_low", 32'(KEY_n), 32'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_KEY_n", 32'(KEY_n), 32'hF);
    chk("rst_async_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_async_cur_code", 32'(cur_code), 32'h0);
    chk("rst_async_found_code", 32'(found_code), 32'h0);
    repeat (2) @(negedge clk);

    // Start ignored while the lock is in programming mode
    lock_setup(8'h9C, 1'b0);
    prog = 1'b1;
    do_start(8'h9C);
    repeat (20) @(negedge clk);
    chk("prog_start_busy", 32'(busy), 32'h0);
    chk("prog_start_KEY_n", 32'(KEY_n), 32'hF);
    prog = 1'b0;
    repeat (2) @(negedge clk);

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    chk("key_exclusive_viol", 32'(viol), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
